// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps an 8-bit ALU through a small on-chip program.
// Each executed entry presents {opcode, immediate, accumulator} to the ALU,
// waits ALU_LAT cycles, then captures the ALU result into the accumulator,
// which becomes operand B of the next entry.
//
// Optional feature macro: ALU_SEQ_REPEAT_EN (adds i_repeat, reruns the program
// i_repeat extra times with the accumulator carried over).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous reset (active-high)
//   ena                 global enable; 0 freezes FSM, counters, accumulator
//   i_wr_en/addr/data   program write port ({opcode[2:0], imm[7:0]}), IDLE only
//   i_len               entries to run (clamped to DEPTH), latched at start
//   i_acc_init          accumulator value loaded at start
//   i_start             run request (ignored while busy)
//   i_repeat            extra passes (ALU_SEQ_REPEAT_EN only)
//   i_result            ALU result
//   o_instruction       ALU opcode, upper 5 bits zero
//   o_data_0 / o_data_1 ALU operands A (immediate) / B (accumulator)
//   o_acc, o_pc         accumulator, in-pass entry index
//   o_busy, o_done      not-idle flag, one-cycle completion pulse
//   o_halted            last run ended on HALT, sticky until next start
`timescale 1ns/1ps

module alu_op_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned ALU_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [10:0]       i_wr_data,
    input  logic [ADDR_W:0]   i_len,
    input  logic [7:0]        i_acc_init,
    input  logic              i_start,
`ifdef ALU_SEQ_REPEAT_EN
    input  logic [3:0]        i_repeat,
`endif
    input  logic [7:0]        i_result,
    output logic [7:0]        o_instruction,
    output logic [7:0]        o_data_0,
    output logic [7:0]        o_data_1,
    output logic [7:0]        o_acc,
    output logic [ADDR_W:0]   o_pc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_halted
);

    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    // WAIT lasts ALU_LAT cycles: the counter runs from ALU_LAT-1 down to 0.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
    localparam logic [ADDR_W:0]  DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StCapture,
        StDone
    } state_e;

    state_e           state_q;
    logic [10:0]      mem_q [DEPTH];
    logic [ADDR_W:0]  pc_q;
    logic [ADDR_W:0]  len_q;
    logic [7:0]       acc_q;
    logic [7:0]       instr_q;
    logic [7:0]       data0_q;
    logic [7:0]       data1_q;
    logic             done_q;
    logic             halted_q;
    logic [CNT_W-1:0] wait_cnt_q;
`ifdef ALU_SEQ_REPEAT_EN
    logic [3:0]       rep_q;
`endif

    logic [10:0]      entry;
    logic [2:0]       entry_op;
    logic [ADDR_W:0]  len_clamped;

    assign entry       = mem_q[pc_q[ADDR_W-1:0]];
    assign entry_op    = entry[10:8];
    assign len_clamped = (i_len > DEPTH_LEN) ? DEPTH_LEN : i_len;

    // Program memory has no reset; writes land only while idle, independent of ena,
    // so a write issued together with start is seen by the first FETCH.
    always_ff @(posedge clk) begin
        if (i_wr_en && (state_q == StIdle)) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            instr_q    <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            wait_cnt_q <= '0;
`ifdef ALU_SEQ_REPEAT_EN
            rep_q      <= '0;
`endif
        end else if (ena) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        acc_q    <= i_acc_init;
                        pc_q     <= '0;
                        len_q    <= len_clamped;
                        halted_q <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
                        rep_q    <= i_repeat;
`endif
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (pc_q == len_q) begin
`ifdef ALU_SEQ_REPEAT_EN
                        if (rep_q != 4'd0) begin
                            rep_q <= rep_q - 4'd1;
                            pc_q  <= '0;
                        end else begin
                            state_q <= StDone;
                        end
`else
                        state_q <= StDone;
`endif
                    end else if (entry_op == OP_NOP) begin
                        pc_q <= pc_q + 1'b1;
                    end else if (entry_op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        instr_q <= {5'b0, entry_op};
                        data0_q <= entry[7:0];
                        data1_q <= acc_q;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (ALU_LAT == 0) begin
                        state_q <= StCapture;
                    end else begin
                        wait_cnt_q <= WAIT_LOAD;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= StCapture;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                StCapture: begin
                    acc_q   <= i_result;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= StFetch;
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_instruction = instr_q;
    assign o_data_0      = data0_q;
    assign o_data_1      = data1_q;
    assign o_acc         = acc_q;
    assign o_pc          = pc_q;
    assign o_busy        = (state_q != StIdle);
    assign o_done        = done_q;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=0 with a combinational
// model ALU, ALU_LAT=2 with a two-stage model ALU) share one stimulus stream.
// Expected completions and issued opcodes are queued at start; negedge
// monitors pop and compare when the DUTs present them.
`timescale 1ns/1ps

module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ena, i_wr_en, i_start;
    logic [2:0]  i_wr_addr;
    logic [10:0] i_wr_data;
    logic [3:0]  i_len;
    logic [7:0]  i_acc_init;
`ifdef ALU_SEQ_REPEAT_EN
    logic [3:0]  i_repeat;
`endif

    logic [7:0] res0, ins0, a0, b0, acc0;
    logic [7:0] res1, ins1, a1, b1, acc1;
    logic [3:0] pc0, pc1;
    logic       busy0, done0, halt0, busy1, done1, halt1;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            3'd0:    return a | b;
            3'd1:    return ~(a & b);
            3'd2:    return ~(a | b);
            3'd3:    return a & b;
            3'd4:    return a + b;
            3'd5:    return b - a;
            default: return 8'h00;
        endcase
    endfunction

    assign res0 = alu_model(ins0[2:0], a0, b0);

    logic [7:0] pipe_s1, pipe_s2;
    always @(posedge clk) begin
        pipe_s1 <= alu_model(ins1[2:0], a1, b1);
        pipe_s2 <= pipe_s1;
    end
    assign res1 = pipe_s2;

    alu_op_sequencer #(.DEPTH(8), .ADDR_W(3), .ALU_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_len(i_len), .i_acc_init(i_acc_init), .i_start(i_start),
`ifdef ALU_SEQ_REPEAT_EN
        .i_repeat(i_repeat),
`endif
        .i_result(res0), .o_instruction(ins0), .o_data_0(a0), .o_data_1(b0), .o_acc(acc0),
        .o_pc(pc0), .o_busy(busy0), .o_done(done0), .o_halted(halt0)
    );

    alu_op_sequencer #(.DEPTH(8), .ADDR_W(3), .ALU_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_len(i_len), .i_acc_init(i_acc_init), .i_start(i_start),
`ifdef ALU_SEQ_REPEAT_EN
        .i_repeat(i_repeat),
`endif
        .i_result(res1), .o_instruction(ins1), .o_data_0(a1), .o_data_1(b1), .o_acc(acc1),
        .o_pc(pc1), .o_busy(busy1), .o_done(done1), .o_halted(halt1)
    );

    typedef struct {
        logic [7:0] acc;
        logic       halted;
        int         lat;
        int         sc;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [2:0] ops_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Completion monitors
    exp_t e0, e1;
    always @(negedge clk) begin
        if (done0) begin
            chk("dut0 done expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("dut0 final acc", acc0, e0.acc);
                chk("dut0 halted", halt0, e0.halted);
                chk("dut0 done latency", cyc - e0.sc, e0.lat);
            end
        end
        if (done1) begin
            chk("dut1 done expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("dut1 final acc", acc1, e1.acc);
                chk("dut1 halted", halt1, e1.halted);
                chk("dut1 done latency", cyc - e1.sc, e1.lat);
            end
        end
    end

    // Issue monitor (dut0): a new operand tuple while busy is one ALU issue.
    logic [23:0] prev_tup = '0;
    always @(negedge clk) begin
        if (busy0 && ({ins0, a0, b0} != prev_tup)) begin
            chk("dut0 issue expected", 32'(ops_q.size() != 0), 1);
            if (ops_q.size() != 0) chk("dut0 issued opcode", ins0, {5'b0, ops_q.pop_front()});
        end
        prev_tup = {ins0, a0, b0};
    end

    task automatic wr(input int addr, input logic [2:0] op, input logic [7:0] imm);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_addr = addr[2:0];
        i_wr_data = {op, imm};
        @(negedge clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic push_ops(input int n, input logic [23:0] list);
        for (int i = 0; i < n; i++) ops_q.push_back(list[3*i +: 3]);
    endtask

    // Returns at the negedge just after the start edge.
    task automatic run(input logic [7:0] init, input logic [3:0] len, input logic [7:0] racc,
                       input logic rhalt, input int lat0, input int lat1);
        exp_t e;
        @(negedge clk);
        i_acc_init = init;
        i_len      = len;
        i_start    = 1'b1;
        e.acc = racc; e.halted = rhalt; e.sc = cyc + 1;
        e.lat = lat0; q0.push_back(e);
        e.lat = lat1; q1.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1) break;
            @(negedge clk);
        end
        chk("runs completed in time", q0.size() + q1.size(), 0);
        chk("all expected ops issued", ops_q.size(), 0);
        q0.delete(); q1.delete(); ops_q.delete();
    endtask

    task automatic write_basic();
        wr(0, 3'd4, 8'h05);
        wr(1, 3'd3, 8'h0C);
        wr(2, 3'd5, 8'h02);
    endtask

    task automatic chk_reset_state();
        chk("rst busy0", busy0, 0);      chk("rst busy1", busy1, 0);
        chk("rst acc0", acc0, 0);        chk("rst acc1", acc1, 0);
        chk("rst instr0", ins0, 0);      chk("rst instr1", ins1, 0);
        chk("rst data0", {a0, b0}, 0);   chk("rst data1", {a1, b1}, 0);
        chk("rst pc0", pc0, 0);          chk("rst pc1", pc1, 0);
        chk("rst done", {done0, done1}, 0);
        chk("rst halted", {halt0, halt1}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; ena = 1'b1; i_wr_en = 1'b0; i_start = 1'b0;
        i_wr_addr = '0; i_wr_data = '0; i_len = '0; i_acc_init = '0;
`ifdef ALU_SEQ_REPEAT_EN
        i_repeat = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        chk_reset_state();

        // Basic run: 0x0A -> 0x0F -> 0x0C -> 0x0A
        write_basic();
        push_ops(3, {15'd0, 3'd5, 3'd3, 3'd4});
        run(8'h0A, 4'd3, 8'h0A, 1'b0, 11, 17);
        wait_idle();

        // ena low for 5 cycles while dut1 sits in WAIT
        push_ops(3, {15'd0, 3'd5, 3'd3, 3'd4});
        run(8'h0A, 4'd3, 8'h0A, 1'b0, 16, 22);
        repeat (7) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_idle();

        // NOP, ADD 1, HALT, ADD 0x80
        wr(0, 3'd6, 8'h00);
        wr(1, 3'd4, 8'h01);
        wr(2, 3'd7, 8'h00);
        wr(3, 3'd4, 8'h80);
        push_ops(1, {21'd0, 3'd4});
        run(8'h00, 4'd4, 8'h01, 1'b1, 6, 8);
        wait_idle();
        chk("halted sticky after run", {halt0, halt1}, 2'b11);

        // Reset mid-run at pc=2: abort, no done
        write_basic();
        push_ops(2, {18'd0, 3'd3, 3'd4});
        @(negedge clk);
        i_acc_init = 8'h0A; i_len = 4'd3; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 50 && pc0 != 4'd2; i++) @(negedge clk);
        chk("dut0 reached pc 2", pc0, 2);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk_reset_state();
        repeat (25) @(negedge clk);
        wait_idle();
        // Program survives reset
        push_ops(3, {15'd0, 3'd5, 3'd3, 3'd4});
        run(8'h0A, 4'd3, 8'h0A, 1'b0, 11, 17);
        wait_idle();

        // i_len = 0
        run(8'h5A, 4'd0, 8'h5A, 1'b0, 2, 2);
        wait_idle();

        // Write and start while busy are ignored: 0x10 -> 0x15 -> 0x04 -> 0x02
        push_ops(3, {15'd0, 3'd5, 3'd3, 3'd4});
        run(8'h10, 4'd3, 8'h02, 1'b0, 11, 17);
        repeat (2) @(negedge clk);
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = {3'd4, 8'h77};
        i_acc_init = 8'hFF; i_start = 1'b1;
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        wait_idle();
        push_ops(3, {15'd0, 3'd5, 3'd3, 3'd4});
        run(8'h10, 4'd3, 8'h02, 1'b0, 11, 17);
        wait_idle();

        // i_len above DEPTH clamps to 8 entries of ADD 1
        for (int i = 0; i < 8; i++) wr(i, 3'd4, 8'h01);
        push_ops(8, {8{3'd4}});
        run(8'h20, 4'd15, 8'h28, 1'b0, 26, 42);
        wait_idle();

`ifdef ALU_SEQ_REPEAT_EN
        // Four passes of ADD 3
        wr(0, 3'd4, 8'h03);
        i_repeat = 4'd3;
        push_ops(4, {12'd0, 3'd4, 3'd4, 3'd4, 3'd4});
        run(8'h00, 4'd1, 8'h0C, 1'b0, 17, 25);
        i_repeat = 4'd0;
        wait_idle();
`endif

        // Same-cycle write and start: run sees OR 0x30 -> 0x3A
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = {3'd0, 8'h30};
        i_acc_init = 8'h0A; i_len = 4'd1; i_start = 1'b1;
        begin
            exp_t e;
            e.acc = 8'h3A; e.halted = 1'b0; e.sc = cyc + 1;
            e.lat = 5; q0.push_back(e);
            e.lat = 7; q1.push_back(e);
        end
        push_ops(1, {21'd0, 3'd0});
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
